// File: rtl/mux_rr_pkg.sv
// rtl/mux_rr_pkg.sv - shared state encoding, widths and helpers for the round-robin mux controller
package mux_rr_pkg;

    localparam int SEL_W  = 2;
    localparam int NUM_CH = 4;

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] SETTLE = 2'd1;
    localparam logic [1:0] WAIT   = 2'd2;

    // One-hot channel mask for a select value.
    function automatic logic [NUM_CH-1:0] ch_onehot(input logic [SEL_W-1:0] s);
        ch_onehot = NUM_CH'(1) << s;
    endfunction

endpackage

// File: rtl/rr_pick4.sv
// rtl/rr_pick4.sv - combinational round-robin pick of one of four requests starting at ptr
module rr_pick4
    import mux_rr_pkg::*;
(
    input  logic [NUM_CH-1:0] req,
    input  logic [SEL_W-1:0]  ptr,
    output logic [SEL_W-1:0]  winner,
    output logic              any
);

    logic [SEL_W-1:0] idx;
    logic             found;

    // Scan ptr, ptr+1, .. (mod 4) and keep the first requesting channel.
    always_comb begin
        winner = '0;
        idx    = '0;
        found  = 1'b0;
        any    = |req;
        for (int i = 0; i < NUM_CH; i++) begin
            idx = ptr + SEL_W'(i);
            if (!found && req[idx]) begin
                winner = idx;
                found  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mux_4to1_rr_ctrl.sv
// rtl/mux_4to1_rr_ctrl.sv - round-robin select controller driving mux_4to1 and capturing its output
module mux_4to1_rr_ctrl
    import mux_rr_pkg::*;
#(
    parameter int WIDTH     = 4,
    parameter int START_PTR = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_CH-1:0] req,
    output logic              S0,
    output logic              S1,
    input  logic [WIDTH-1:0]  Y,
    output logic [WIDTH-1:0]  dout,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [NUM_CH-1:0] ack,
    output logic              busy
);

    logic [1:0]       state;
    logic [SEL_W-1:0] sel;
    logic [SEL_W-1:0] ptr;
    logic [SEL_W-1:0] winner;
    logic             any;

    rr_pick4 u_pick (
        .req    (req),
        .ptr    (ptr),
        .winner (winner),
        .any    (any)
    );

    // IDLE -> SETTLE -> WAIT -> IDLE; select is latched at grant and held until the word is accepted.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            sel       <= '0;
            dout      <= '0;
            out_valid <= 1'b0;
            ack       <= '0;
            ptr       <= SEL_W'(START_PTR);
        end else begin
            ack <= '0;
            case (state)
                IDLE: begin
                    if (any) begin
                        sel   <= winner;
                        state <= SETTLE;
                    end
                end
                SETTLE: begin
                    // Y has had a full cycle to follow the new select.
                    dout      <= Y;
                    out_valid <= 1'b1;
                    state     <= WAIT;
                end
                WAIT: begin
                    if (out_valid && out_ready) begin
                        out_valid <= 1'b0;
                        ack       <= ch_onehot(sel);
                        ptr       <= sel + SEL_W'(1);
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign S0   = sel[0];
    assign S1   = sel[1];
    assign busy = (state != IDLE);

endmodule
